// File: rtl/cw_sequencer.sv
// Programmable control-word sequencer: replays {last, hold, cw} entries from an
// on-chip table onto the data_path control inputs, with loop, single-step and abort.
module cw_sequencer #(
    parameter int CW_WIDTH   = 17,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int HOLD_W     = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         prog_we,
    input  logic [ADDR_W-1:0]            prog_addr,
    input  logic [CW_WIDTH+HOLD_W:0]     prog_data,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         step_mode,
    input  logic                         step,
    input  logic                         loop_en,
    output logic [CW_WIDTH-1:0]          cw_out,
    output logic                         cw_valid,
    output logic [ADDR_W-1:0]            pc_out,
    output logic                         busy,
    output logic                         done,
    output logic                         prog_err
);

    localparam int ENTRY_W  = CW_WIDTH + HOLD_W + 1;
    localparam int GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W    = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [ADDR_W-1:0] PC_MAX = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t              state_reg, state_next, adv_state;
    logic [ADDR_W-1:0]   pc_reg, pc_next, adv_pc;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                prog_err_reg;
    logic [ENTRY_W-1:0]  tbl_reg [DEPTH];

    logic [CW_WIDTH-1:0] cur_cw;
    logic [HOLD_W-1:0]   cur_hold;
    logic                cur_last;
    logic                wr_en;

    assign cur_cw   = tbl_reg[pc_reg][CW_WIDTH-1:0];
    assign cur_hold = tbl_reg[pc_reg][CW_WIDTH+HOLD_W-1:CW_WIDTH];
    assign cur_last = tbl_reg[pc_reg][ENTRY_W-1];
    assign wr_en    = prog_we && (state_reg == ST_IDLE);

    // Table contents only change in IDLE, so the combinational read is stable during a run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_reg[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_reg[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            cnt_reg      <= '0;
            prog_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            cnt_reg      <= cnt_next;
            prog_err_reg <= prog_we && (state_reg != ST_IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;

        // Where the run goes once the current entry is finished, step_mode aside.
        adv_state = ST_DRIVE;
        adv_pc    = pc_reg + 1'b1;
        if (cur_last || (pc_reg == PC_MAX)) begin
            adv_state = loop_en ? ST_DRIVE : ST_DONE;
            adv_pc    = loop_en ? '0 : pc_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_DRIVE;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_reg == CNT_W'(cur_hold)) begin
                    cnt_next = '0;
                    if (GAP_CYCLES > 0) begin
                        state_next = ST_GAP;
                    end else if (step_mode) begin
                        state_next = ST_PAUSE;
                    end else begin
                        state_next = adv_state;
                        pc_next    = adv_pc;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == CNT_W'(GAP_LAST)) begin
                    cnt_next = '0;
                    if (step_mode) begin
                        state_next = ST_PAUSE;
                    end else begin
                        state_next = adv_state;
                        pc_next    = adv_pc;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (step || !step_mode) begin
                    state_next = adv_state;
                    pc_next    = adv_pc;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    assign cw_out   = (state_reg == ST_DRIVE) ? cur_cw : '0;
    assign cw_valid = (state_reg == ST_DRIVE);
    assign pc_out   = pc_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign prog_err = prog_err_reg;

endmodule

// File: tb/tb_cw_sequencer.sv
// Directed bench for cw_sequencer: run, loop/abort, single-step, full depth,
// write-while-busy and asynchronous reset scenarios.
module tb_cw_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [21:0] prog_data = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        loop_en = 1'b0;
    logic [16:0] cw_out;
    logic        cw_valid;
    logic [4:0]  pc_out;
    logic        busy;
    logic        done;
    logic        prog_err;

    int n_checks = 0;
    int n_pass   = 0;

    cw_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .abort     (abort),
        .step_mode (step_mode),
        .step      (step),
        .loop_en   (loop_en),
        .cw_out    (cw_out),
        .cw_valid  (cw_valid),
        .pc_out    (pc_out),
        .busy      (busy),
        .done      (done),
        .prog_err  (prog_err)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled at negedges, between posedges.
    task automatic do_reset();
        @(negedge clk);
        {prog_we, start, abort, step_mode, step, loop_en} = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic prog_write(input logic [4:0] addr, input logic [21:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
        $display("write: addr=%0d data=%h", addr, data);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_checks++;
        if ({cw_out, cw_valid, pc_out, busy, done, prog_err} !== 27'd0)
            $display("FAIL reset_outputs: got cw=%h v=%b pc=%0d busy=%b done=%b err=%b, want all 0",
                     cw_out, cw_valid, pc_out, busy, done, prog_err);
        else n_pass++;
        do_reset();
        n_checks++;
        if ({cw_out, cw_valid, busy, done} !== 20'd0)
            $display("FAIL reset_idle: got cw=%h v=%b busy=%b done=%b, want 0", cw_out, cw_valid, busy, done);
        else n_pass++;
    endtask

    task automatic test_run();
        logic [16:0] exp_cw   [8] = '{17'h08640, 17'h08640, 17'h0, 17'h0A040, 17'h0A040, 17'h0, 17'h0, 17'h0};
        logic [2:0]  exp_ctl  [8] = '{3'b110, 3'b110, 3'b010, 3'b110, 3'b110, 3'b010, 3'b011, 3'b000};
        $display("scenario: two-entry run");
        do_reset();
        prog_write(5'd0, {1'b0, 4'd1, 17'h08640});
        prog_write(5'd1, {1'b1, 4'd1, 17'h0A040});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (cw_out !== exp_cw[c])
                $display("FAIL run_cw c%0d: got %h want %h", c, cw_out, exp_cw[c]);
            else n_pass++;
            n_checks++;
            if ({cw_valid, busy, done} !== exp_ctl[c])
                $display("FAIL run_ctl c%0d: got v/busy/done=%b want %b", c, {cw_valid, busy, done}, exp_ctl[c]);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (pc_out !== 5'd1) $display("FAIL run_pc_hold: got %0d want 1", pc_out);
        else n_pass++;
    endtask

    task automatic test_loop_abort();
        logic [4:0]  exp_pc;
        logic        exp_v;
        $display("scenario: loop with abort");
        do_reset();
        for (int i = 0; i < 4; i++) prog_write(5'(i), {(i == 3), 4'd0, 17'h06180 + 17'(i)});
        loop_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            exp_pc = 5'(((c - 1) / 2) % 4);
            exp_v  = (c % 2 == 1);
            n_checks++;
            if ({pc_out, cw_valid, done} !== {exp_pc, exp_v, 1'b0})
                $display("FAIL loop_pc c%0d: got pc=%0d v=%b done=%b want pc=%0d v=%b done=0",
                         c, pc_out, cw_valid, done, exp_pc, exp_v);
            else n_pass++;
            n_checks++;
            if (cw_out !== (exp_v ? 17'h06180 + 17'(exp_pc) : 17'h0))
                $display("FAIL loop_cw c%0d: got %h", c, cw_out);
            else n_pass++;
            if (c < 13) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({cw_out, cw_valid, busy, done} !== 20'd0)
                $display("FAIL abort_idle c%0d: got cw=%h v=%b busy=%b done=%b want 0", c, cw_out, cw_valid, busy, done);
            else n_pass++;
            @(negedge clk);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_step();
        $display("scenario: single-step");
        do_reset();
        for (int i = 0; i < 3; i++) prog_write(5'(i), {(i == 2), 4'd0, 17'h00100 + 17'(i)});
        step_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if ({cw_out, cw_valid, pc_out, done} !== {17'h00100 + 17'(s), 1'b1, 5'(s), 1'b0})
                $display("FAIL step_drive s%0d: got cw=%h v=%b pc=%0d done=%b", s, cw_out, cw_valid, pc_out, done);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({cw_out, cw_valid} !== 18'd0) $display("FAIL step_gap s%0d: got cw=%h v=%b want 0", s, cw_out, cw_valid);
            else n_pass++;
            repeat (4) begin
                @(negedge clk);
                n_checks++;
                if ({cw_out, cw_valid, busy, pc_out, done} !== {17'h0, 1'b0, 1'b1, 5'(s), 1'b0})
                    $display("FAIL step_pause s%0d: got cw=%h v=%b busy=%b pc=%0d done=%b",
                             s, cw_out, cw_valid, busy, pc_out, done);
                else n_pass++;
            end
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
        n_checks++;
        if ({done, pc_out} !== {1'b1, 5'd2}) $display("FAIL step_done: got done=%b pc=%0d want 1/2", done, pc_out);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL step_idle: got busy=%b want 0", busy);
        else n_pass++;
        step_mode = 1'b0;
    endtask

    task automatic test_full_depth();
        int errs;
        $display("scenario: full depth without last flag");
        do_reset();
        for (int i = 0; i < 32; i++) prog_write(5'(i), {1'b0, 4'd0, 17'(i + 1)});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        errs = 0;
        for (int c = 1; c <= 64; c++) begin
            if (c % 2 == 1) begin
                n_checks++;
                if ({cw_out, pc_out, done} !== {17'((c - 1) / 2 + 1), 5'((c - 1) / 2), 1'b0})
                    $display("FAIL depth_drive c%0d: got cw=%h pc=%0d done=%b", c, cw_out, pc_out, done);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if ({done, pc_out} !== {1'b1, 5'd31}) $display("FAIL depth_done: got done=%b pc=%0d want 1/31", done, pc_out);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, pc_out} !== {1'b0, 5'd31}) $display("FAIL depth_idle: got busy=%b pc=%0d want 0/31", busy, pc_out);
        else n_pass++;
    endtask

    task automatic test_prog_err();
        int cyc;
        $display("scenario: write while busy");
        do_reset();
        prog_write(5'd0, {1'b0, 4'd1, 17'h08640});
        prog_write(5'd1, {1'b1, 4'd1, 17'h0A040});
        n_checks++;
        if (prog_err !== 1'b0) $display("FAIL err_idle_write: got %b want 0", prog_err);
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b1;
        prog_addr = 5'd0;
        prog_data = '1;
        @(negedge clk);
        prog_we = 1'b0;
        n_checks++;
        if (prog_err !== 1'b1) $display("FAIL err_pulse: got %b want 1", prog_err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (prog_err !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", prog_err);
        else n_pass++;
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL err_run_end: busy=%b after %0d cycles", busy, cyc);
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({cw_out, cw_valid} !== {17'h08640, 1'b1}) $display("FAIL err_table_kept: got cw=%h v=%b want 08640/1", cw_out, cw_valid);
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        $display("scenario: asynchronous reset mid-run");
        do_reset();
        prog_write(5'd0, {1'b1, 4'd3, 17'h08640});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({cw_out, cw_valid} !== {17'h08640, 1'b1}) $display("FAIL arst_pre: got cw=%h v=%b", cw_out, cw_valid);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({cw_out, cw_valid, pc_out, busy, done, prog_err} !== 27'd0)
            $display("FAIL arst_immediate: got cw=%h v=%b pc=%0d busy=%b want 0", cw_out, cw_valid, pc_out, busy);
        else n_pass++;
        #1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({cw_out, cw_valid, pc_out} !== {17'h0, (c % 2 == 1), 5'((c - 1) / 2)})
                $display("FAIL arst_zero_table c%0d: got cw=%h v=%b pc=%0d", c, cw_out, cw_valid, pc_out);
            else n_pass++;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_loop_abort();
        test_step();
        test_full_depth();
        test_prog_err();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cw_sequencer.md
Name: cw_sequencer

Overview:
Programmable control-word sequencer that drives the data_path control inputs from a small on-chip table, so the data path can be exercised on silicon without the hard-wired control unit. Each table entry holds one control word, a hold count and a last flag. The sequencer supports run-to-completion, loop and single-step modes, plus abort. It sits between a debug/programming master and data_path.

Parameters:
CW_WIDTH, 17, control word width
DEPTH, 32, table entries (power of two)
ADDR_W, 5, log2(DEPTH)
HOLD_W, 4, hold-count field width
GAP_CYCLES, 1, idle (all-zero) cycles inserted after each entry; 0 allowed

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
prog_we  in  1  table write strobe
prog_addr  in  ADDR_W  table write index
prog_data  in  CW_WIDTH+HOLD_W+1  {last, hold, cw}
start  in  1  begin run at entry 0 (sampled in IDLE only)
abort  in  1  terminate run
step_mode  in  1  1 = pause after each entry
step  in  1  advance one entry while paused
loop_en  in  1  restart at entry 0 after last entry
cw_out  out  CW_WIDTH  control word to data_path
cw_valid  out  1  high while an entry is driven
pc_out  out  ADDR_W  current entry index
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at normal completion
prog_err  out  1  one-cycle pulse on write attempted while busy

Behaviour:
- Reset: all outputs 0, state IDLE, all table entries cleared to 0.
- cw_out bit map (default width): [16:15] reg_write, [14] imm_mux_ctrl, [13] alu_mux_ctrl, [12:9] alu_op, [8] dmem_enable, [7] dmem_write_enable, [6:5] reg_write_mux_ctrl, [4:0] br_op.
- Table is a register array with combinational read.
- Writes: accepted only in IDLE and take effect at the next edge. prog_we while busy -> write dropped, prog_err pulses the next cycle.
- States: IDLE, DRIVE, GAP, PAUSE, DONE.
- IDLE:
  - cw_out=0, cw_valid=0.
  - start=1 at edge k -> DRIVE, pc=0; entry 0 appears on cw_out after edge k (1-cycle latency).
- DRIVE:
  - cw_out=table[pc].cw, cw_valid=1, for exactly hold+1 cycles, counted by an internal counter.
  - Then -> GAP if GAP_CYCLES>0, else directly to the next-entry decision.
- GAP: cw_out=0, cw_valid=0 for GAP_CYCLES cycles; pc unchanged.
- Next-entry decision, taken after DRIVE or GAP completes:
  - If step_mode=1 -> PAUSE.
  - Else if the entry is last, or pc=DEPTH-1:
    - loop_en=1 -> DRIVE with pc=0.
    - loop_en=0 -> DONE.
  - Else -> DRIVE with pc+1.
- PAUSE:
  - cw_out=0, cw_valid=0.
  - step=1 -> same next-entry rules as above, ignoring step_mode.
  - step_mode deasserted while in PAUSE -> continue as if step had been asserted.
- DONE: done=1 for one cycle, cw_out=0, -> IDLE. pc_out holds the final index until the next start.
- pc wrap: pc never increments past DEPTH-1; the implicit last entry is DEPTH-1.
- abort=1 in any non-IDLE state -> IDLE at the next edge; cw_out=0, done not asserted.
- Priority: abort > step > start. start while busy is ignored.
- Reset mid-run: immediate return to the reset state; table contents are lost.

Test Plan:
- Program entry0 = {0,1,0x08640} (xor: reg_write=01, alu_op=0011, rwm=10) and entry1 = {1,1,0x0A040} (addi: alu_mux=1); pulse start; GAP_CYCLES=1 -> sequence is 0x08640 ×2, 0 ×1, 0x0A040 ×2, 0 ×1, then done pulse; busy high for 7 cycles.
- Four store entries {hold=0, cw=0x06180 style, last only on entry3}, loop_en=1 -> pc_out follows 0,1,2,3,0,…; abort mid-entry2 -> cw_out=0 next cycle, no done.
- step_mode=1, 3 entries -> after each entry plus gap, PAUSE holds cw_out=0 indefinitely; each step pulse advances exactly one entry; done only after the third step.
- No last flag anywhere, DEPTH=32 -> run stops after pc=31 with done; pc_out=31.
- prog_we during run -> prog_err pulse; table unchanged, verified by rerunning.
- Assert rst=0 during DRIVE -> all outputs 0 immediately, asynchronous to clk; the next start drives an all-zero table (cw_out=0, cw_valid=1 for 1 cycle per entry).
